// File: rtl/pe_lsu_ctrl_if.sv
// Data-memory request/acknowledge bus between the PE load/store sequencer
// and data memory.
interface pe_lsu_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();
  logic                mem_req;
  logic                mem_we;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_be;
  logic                mem_ack;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/pe_lsu_ctrl.sv
// PE load/store sequencer: forms the effective address, checks legality and
// alignment, runs a bounded req/ack memory transaction, extends load data.
module pe_lsu_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   base,
  input  logic [11:0]       imm12,
  input  logic [XLEN-1:0]   store_data,
  input  logic [4:0]        rd,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic [4:0]        rd_out,
  output logic              rd_write,
  output logic [XLEN-1:0]   rd_data,
  pe_lsu_ctrl_if.master     mem
);

  localparam int unsigned NB     = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_RESP,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;

  logic              op_store_q, op_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   base_q, base_d;
  logic [11:0]       imm_q, imm_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_cause_q, fault_cause_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              rd_write_q, rd_write_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;

  logic [XLEN-1:0]   ea;
  logic [LANE_W-1:0] lane;
  logic [1:0]        size;
  logic              illegal;
  logic              misaligned;
  logic [NB-1:0]     be_mask;
  logic [XLEN-1:0]   lane_rdata;
  logic [XLEN-1:0]   load_ext;

  // Address, access checks and lane steering from the latched operands.
  always_comb begin
    ea   = base_q + XLEN'($signed(imm_q));
    lane = ea[LANE_W-1:0];
    size = funct3_q[1:0];

    if (op_store_q) begin
      illegal = funct3_q[2] || (XLEN == 32 && size == 2'd3);
    end else begin
      illegal = (funct3_q == 3'b111) ||
                (XLEN == 32 && (funct3_q == 3'b011 || funct3_q == 3'b110));
    end

    unique case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = ea[0];
      2'd2:    misaligned = |ea[1:0];
      default: misaligned = |ea[2:0];
    endcase

    unique case (size)
      2'd0:    be_mask = NB'(1);
      2'd1:    be_mask = NB'(3);
      2'd2:    be_mask = NB'(15);
      default: be_mask = '1;
    endcase

    lane_rdata = mem.mem_rdata >> {lane, 3'b000};

    // funct3[2] selects zero extension (LBU/LHU/LWU).
    unique case (size)
      2'd0: begin
        if (funct3_q[2]) load_ext = XLEN'(lane_rdata[7:0]);
        else             load_ext = XLEN'($signed(lane_rdata[7:0]));
      end
      2'd1: begin
        if (funct3_q[2]) load_ext = XLEN'(lane_rdata[15:0]);
        else             load_ext = XLEN'($signed(lane_rdata[15:0]));
      end
      2'd2: begin
        if (funct3_q[2]) load_ext = XLEN'(lane_rdata[31:0]);
        else             load_ext = XLEN'($signed(lane_rdata[31:0]));
      end
      default: load_ext = lane_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    op_store_d    = op_store_q;
    funct3_d      = funct3_q;
    base_d        = base_q;
    imm_d         = imm_q;
    sdata_d       = sdata_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + CNT_W'(1);
    fault_cause_d = fault_cause_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    rd_out_d      = rd_out_q;
    rd_data_d     = rd_data_q;
    rd_write_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_store_d    = is_store;
          funct3_d      = funct3;
          base_d        = base;
          imm_d         = imm12;
          sdata_d       = store_data;
          rd_d          = rd;
          fault_cause_d = 2'b00;
          state_d       = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal) begin
          fault_cause_d = CAUSE_ILLEGAL;
          state_d       = S_FAULT;
        end else if (misaligned) begin
          fault_cause_d = CAUSE_MISALIGN;
          state_d       = S_FAULT;
        end else begin
          cnt_d       = '0;
          mem_we_d    = op_store_q;
          mem_addr_d  = ea & ~XLEN'(NB - 1);
          mem_wdata_d = op_store_q ? (sdata_q << {lane, 3'b000}) : '0;
          mem_be_d    = op_store_q ? (be_mask << lane) : '1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // An ack on the timeout edge still completes the access.
        if (mem.mem_ack) begin
          state_d = S_RESP;
          if (!op_store_q) begin
            rd_data_d  = load_ext;
            rd_out_d   = rd_q;
            rd_write_d = (rd_q != 5'd0);
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          fault_cause_d = CAUSE_TIMEOUT;
          state_d       = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_RESP);
    fault_d   = (state_d == S_FAULT);
    mem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_store_q    <= 1'b0;
      funct3_q      <= '0;
      base_q        <= '0;
      imm_q         <= '0;
      sdata_q       <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      rd_out_q      <= '0;
      rd_write_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      op_store_q    <= op_store_d;
      funct3_q      <= funct3_d;
      base_q        <= base_d;
      imm_q         <= imm_d;
      sdata_q       <= sdata_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      rd_out_q      <= rd_out_d;
      rd_write_q    <= rd_write_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_cause   = fault_cause_q;
  assign rd_out        = rd_out_q;
  assign rd_write      = rd_write_q;
  assign rd_data       = rd_data_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

endmodule
